msi_snoop_cache_ctrl: RTL

//  Parametrised per-CPU snooping cache controller: direct-mapped cache of LINES lines, MSI coherence.

---
 rtl/msi_snoop_cache_ctrl_pkg.sv | 34 +++
 rtl/msi_snoop_cache_ctrl_if.sv | 26 ++
 rtl/msi_snoop_cache_ctrl_line_store.sv | 60 ++++++
 rtl/msi_snoop_cache_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/msi_snoop_cache_ctrl_pkg.sv
// Shared definitions for the MSI snooping cache controller: line states, FSM
// encoding and bit positions of the bus request and snoop message fields.
package msi_pkg;

    localparam logic [1:0] LS_I = 2'b00;
    localparam logic [1:0] LS_S = 2'b01;
    localparam logic [1:0] LS_M = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_WB     = 3'd2,
        ST_BUS    = 3'd3,
        ST_DONE   = 3'd4
    } fsm_e;

    // Offsets inside the 3-bit opcode that sits above {addr, data} in bus_out
    localparam int BUS_RM_OFS  = 2;
    localparam int BUS_WM_OFS  = 1;
    localparam int BUS_INV_OFS = 0;

    localparam int SNP_RM  = 2;
    localparam int SNP_WM  = 1;
    localparam int SNP_INV = 0;

    localparam logic [2:0] OP_RM  = 3'b100;
    localparam logic [2:0] OP_WM  = 3'b010;
    localparam logic [2:0] OP_INV = 3'b001;

    function automatic logic [2:0] miss_op(input logic is_write);
        return is_write ? OP_WM : OP_RM;
    endfunction

endpackage

// File: rtl/msi_snoop_cache_ctrl_if.sv
// Bus-side signals of one cache controller: outgoing request, ack/fill,
// incoming snoop traffic and the flush (writeback) channel.
interface msi_snoop_cache_ctrl_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
);
    logic [3+ADDR_W+DATA_W-1:0] bus_out;
    logic                       bus_ack;
    logic [DATA_W-1:0]          bus_data;
    logic                       snoop_valid;
    logic [2:0]                 snoop_msg;
    logic [ADDR_W-1:0]          snoop_addr;
    logic                       flush_valid;
    logic [ADDR_W-1:0]          flush_addr;
    logic [DATA_W-1:0]          flush_data;

    modport master (
        output bus_out, flush_valid, flush_addr, flush_data,
        input  bus_ack, bus_data, snoop_valid, snoop_msg, snoop_addr
    );

    modport slave (
        input  bus_out, flush_valid, flush_addr, flush_data,
        output bus_ack, bus_data, snoop_valid, snoop_msg, snoop_addr
    );
endinterface

// File: rtl/msi_snoop_cache_ctrl_line_store.sv
// Direct-mapped line array {state, tag, data}: one local write port, one
// snoop state-only write port, two combinational read ports.
module msi_line_store
    import msi_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4,
    parameter int LINES  = 2,
    localparam int IDX_W = $clog2(LINES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lwr_en_i,
    input  logic [IDX_W-1:0]  lwr_idx_i,
    input  logic [1:0]        lwr_state_i,
    input  logic [ADDR_W-1:0] lwr_tag_i,
    input  logic [DATA_W-1:0] lwr_data_i,
    input  logic              snp_en_i,
    input  logic [IDX_W-1:0]  snp_idx_i,
    input  logic [1:0]        snp_state_i,
    input  logic [IDX_W-1:0]  l_idx_i,
    output logic [1:0]        l_state_o,
    output logic [ADDR_W-1:0] l_tag_o,
    output logic [DATA_W-1:0] l_data_o,
    input  logic [IDX_W-1:0]  s_idx_i,
    output logic [1:0]        s_state_o,
    output logic [ADDR_W-1:0] s_tag_o,
    output logic [DATA_W-1:0] s_data_o
);
    logic [1:0]        state_q [LINES];
    logic [ADDR_W-1:0] tag_q   [LINES];
    logic [DATA_W-1:0] data_q  [LINES];

    // Local write is issued after the snoop update so a same-cycle fill overwrites it
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) begin
                state_q[i] <= LS_I;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            if (snp_en_i) begin
                state_q[snp_idx_i] <= snp_state_i;
            end
            if (lwr_en_i) begin
                state_q[lwr_idx_i] <= lwr_state_i;
                tag_q[lwr_idx_i]   <= lwr_tag_i;
                data_q[lwr_idx_i]  <= lwr_data_i;
            end
        end
    end

    assign l_state_o = state_q[l_idx_i];
    assign l_tag_o   = tag_q[l_idx_i];
    assign l_data_o  = data_q[l_idx_i];
    assign s_state_o = state_q[s_idx_i];
    assign s_tag_o   = tag_q[s_idx_i];
    assign s_data_o  = data_q[s_idx_i];
endmodule

// File: rtl/msi_snoop_cache_ctrl.sv
// Per-CPU MSI snooping cache controller: FSM for one local op at a time,
// hit/miss and victim handling, snoop decode and flush arbitration.
module msi_snoop_cache_ctrl
    import msi_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4,
    parameter int LINES  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  execute_instruction,
    input  logic                  instruction,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     data_in,
    output logic [DATA_W-1:0]     data_out,
    output logic                  done,
    msi_snoop_cache_ctrl_if.master bus
);
    localparam int IDX_W  = $clog2(LINES);
    localparam int BUS_W  = 3 + ADDR_W + DATA_W;
    localparam int OP_LSB = ADDR_W + DATA_W;

    fsm_e              state_q, state_d;
    logic              instr_q, instr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              done_q, done_d;
    logic [BUS_W-1:0]  bus_out_q, bus_out_d;
    logic              flush_valid_q, flush_valid_d;
    logic [ADDR_W-1:0] flush_addr_q, flush_addr_d;
    logic [DATA_W-1:0] flush_data_q, flush_data_d;

    logic [IDX_W-1:0]  l_idx, s_idx;
    logic [1:0]        l_state, s_state, lwr_state, snp_state;
    logic [ADDR_W-1:0] l_tag, s_tag, lwr_tag;
    logic [DATA_W-1:0] l_data, s_data, lwr_data;
    logic              lwr_en, snp_en, snp_flush;
    logic              snp_match, snp_rm, snp_kill;
    logic              hit, victim_dirty, lookup_stall, pend_inv_hit;

    msi_line_store #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES)) u_store (
        .clock       (clock),
        .reset       (reset),
        .lwr_en_i    (lwr_en),
        .lwr_idx_i   (l_idx),
        .lwr_state_i (lwr_state),
        .lwr_tag_i   (lwr_tag),
        .lwr_data_i  (lwr_data),
        .snp_en_i    (snp_en),
        .snp_idx_i   (s_idx),
        .snp_state_i (snp_state),
        .l_idx_i     (l_idx),
        .l_state_o   (l_state),
        .l_tag_o     (l_tag),
        .l_data_o    (l_data),
        .s_idx_i     (s_idx),
        .s_state_o   (s_state),
        .s_tag_o     (s_tag),
        .s_data_o    (s_data)
    );

    assign l_idx        = addr_q[IDX_W-1:0];
    assign s_idx        = bus.snoop_addr[IDX_W-1:0];
    assign snp_match    = bus.snoop_valid && (s_state != LS_I) && (s_tag == bus.snoop_addr);
    assign snp_rm       = bus.snoop_msg[SNP_RM];
    assign snp_kill     = bus.snoop_msg[SNP_WM] | bus.snoop_msg[SNP_INV];
    assign hit          = (l_state != LS_I) && (l_tag == addr_q);
    assign victim_dirty = !hit && (l_state == LS_M);
    // Re-evaluate next cycle if the snoop touches our line or owns the flush port
    assign lookup_stall = (snp_en && (s_idx == l_idx)) || (snp_flush && victim_dirty);
    assign pend_inv_hit = bus_out_q[OP_LSB+BUS_INV_OFS] && bus.snoop_valid && snp_kill
                          && (bus.snoop_addr == addr_q);

    // Snoop-side state change and flush request
    always_comb begin
        snp_en    = 1'b0;
        snp_state = s_state;
        snp_flush = 1'b0;
        if (snp_match && snp_kill) begin
            snp_en    = 1'b1;
            snp_state = LS_I;
            snp_flush = (s_state == LS_M);
        end else if (snp_match && snp_rm && (s_state == LS_M)) begin
            snp_en    = 1'b1;
            snp_state = LS_S;
            snp_flush = 1'b1;
        end else begin
            snp_en    = 1'b0;
        end
    end

    // Controller next state, local line writes and outputs
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        data_out_d    = data_out_q;
        done_d        = done_q;
        bus_out_d     = bus_out_q;
        flush_valid_d = snp_flush;
        flush_addr_d  = flush_addr_q;
        flush_data_d  = flush_data_q;
        lwr_en        = 1'b0;
        lwr_state     = l_state;
        lwr_tag       = addr_q;
        lwr_data      = l_data;
        if (snp_flush) begin
            flush_addr_d = bus.snoop_addr;
            flush_data_d = s_data;
        end else begin
            flush_addr_d = flush_addr_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (execute_instruction) begin
                    instr_d = instruction;
                    addr_d  = address;
                    wdata_d = data_in;
                    done_d  = 1'b0;
                    state_d = ST_LOOKUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (lookup_stall) begin
                    state_d = ST_LOOKUP;
                end else if (hit && !instr_q) begin
                    data_out_d = l_data;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end else if (hit && (l_state == LS_M)) begin
                    lwr_en    = 1'b1;
                    lwr_state = LS_M;
                    lwr_data  = wdata_q;
                    state_d   = ST_DONE;
                end else if (hit) begin
                    bus_out_d = {OP_INV, addr_q, {DATA_W{1'b0}}};
                    state_d   = ST_BUS;
                end else if (victim_dirty) begin
                    flush_valid_d = 1'b1;
                    flush_addr_d  = l_tag;
                    flush_data_d  = l_data;
                    lwr_en        = 1'b1;
                    lwr_state     = LS_I;
                    lwr_tag       = l_tag;
                    state_d       = ST_WB;
                end else begin
                    bus_out_d = {miss_op(instr_q), addr_q, {DATA_W{1'b0}}};
                    state_d   = ST_BUS;
                end
            end
            ST_WB: begin
                bus_out_d = {miss_op(instr_q), addr_q, {DATA_W{1'b0}}};
                state_d   = ST_BUS;
            end
            ST_BUS: begin
                if (bus.bus_ack) begin
                    bus_out_d = '0;
                    lwr_en    = 1'b1;
                    if (bus_out_q[OP_LSB+BUS_RM_OFS]) begin
                        lwr_state = LS_S;
                        lwr_data  = bus.bus_data;
                    end else begin
                        lwr_state = LS_M;
                        lwr_data  = wdata_q;
                    end
                    state_d = ST_DONE;
                end else if (pend_inv_hit) begin
                    // Our S copy was just invalidated, so the upgrade must refetch ownership
                    bus_out_d = {OP_WM, addr_q, {DATA_W{1'b0}}};
                end else begin
                    state_d = ST_BUS;
                end
            end
            ST_DONE: begin
                data_out_d = l_data;
                done_d     = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            instr_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            data_out_q    <= '0;
            done_q        <= 1'b1;
            bus_out_q     <= '0;
            flush_valid_q <= 1'b0;
            flush_addr_q  <= '0;
            flush_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            data_out_q    <= data_out_d;
            done_q        <= done_d;
            bus_out_q     <= bus_out_d;
            flush_valid_q <= flush_valid_d;
            flush_addr_q  <= flush_addr_d;
            flush_data_q  <= flush_data_d;
        end
    end

    assign data_out        = data_out_q;
    assign done            = done_q;
    assign bus.bus_out     = bus_out_q;
    assign bus.flush_valid = flush_valid_q;
    assign bus.flush_addr  = flush_addr_q;
    assign bus.flush_data  = flush_data_q;
endmodule
